mem_lsu: RTL

Load/store unit for the data memory: the initiator side of the memory's word-wide port (word write port, combinational read port). It accepts byte/half/word load and store requests from the core pipeline over a valid/ready handshake and converts byte addresses to word indices. It performs sign/zero extension on loads and implements sub-word stores as read-modify-write, because the memory only supports full-word writes. It sits between the execute stage and the data memory instance.

---
 rtl/mem_lsu_pkg.sv | 29 ++
 rtl/mem_lsu_lane.sv | 44 ++++
 rtl/mem_lsu.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings, FSM states
// and the alignment rule used when MEM_LSU_ALIGN_CHECK_EN is defined.
package mem_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LD   = 3'd1,
        ST   = 3'd2,
        RD   = 3'd3,
        WR   = 3'd4,
        RESP = 3'd5
    } state_t;

    // Size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = lo[0];
            default: mis = (lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lsu_lane.sv
// Combinational lane logic: load-side lane extract with sign/zero extension and
// store-side lane merge for sub-word read-modify-write.
module mem_lsu_lane
    import mem_lsu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] i_rdata,
    input  logic [N-1:0] i_old,
    input  logic [N-1:0] i_wdata,
    input  logic [1:0]   i_addr_lo,
    input  logic [1:0]   i_size,
    input  logic         i_unsigned,
    output logic [N-1:0] o_load,
    output logic [N-1:0] o_merge
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    // Select the addressed lane for loads and splice new data into the old word for stores.
    always_comb begin
        o_load  = i_rdata;
        o_merge = i_old;
        case (i_size)
            SZ_BYTE: begin
                o_load = {{(N-8){~i_unsigned & w_byte[7]}}, w_byte};
                o_merge[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            end
            SZ_HALF: begin
                o_load = {{(N-16){~i_unsigned & w_half[15]}}, w_half};
                o_merge[{i_addr_lo[1], 4'b0000} +: 16] = i_wdata[15:0];
            end
            default: begin
                o_load  = i_rdata;
                o_merge = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit in front of a word-wide data memory; sub-word stores use RMW.
// Optional misalignment check enabled by defining MEM_LSU_ALIGN_CHECK_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_we,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [N-1:0] req_addr,
    input  logic [N-1:0] req_wdata,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_rdata,
    output logic         rsp_err,
    output logic [M-1:0] mem_adrs_r,
    input  logic [N-1:0] mem_data_r,
    output logic [M-1:0] mem_adrs_w,
    output logic [N-1:0] mem_data_w,
    output logic         mem_WE
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [M-1:0] r_idx;
    logic [1:0]   r_lo;
    logic [1:0]   r_size;
    logic         r_uns;
    logic [N-1:0] r_wdata;
    logic [N-1:0] r_old;
    logic [N-1:0] r_rdata;
    logic         r_err;
    logic         w_accept;
    logic         w_misalign;
    logic         w_subword;
    logic [N-1:0] w_load;
    logic [N-1:0] w_merge;
    logic         w_unused_addr;

    // Address bits above the memory depth wrap and are intentionally dropped.
    assign w_unused_addr = ^req_addr[N-1:M+2];

`ifdef MEM_LSU_ALIGN_CHECK_EN
    assign w_misalign = is_misaligned(req_size, req_addr[1:0]);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_accept  = req_valid && (r_state == IDLE);
    assign w_subword = (req_size == SZ_BYTE) || (req_size == SZ_HALF);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (!req_valid) begin
                    w_state_nxt = IDLE;
                end else if (w_misalign) begin
                    w_state_nxt = RESP;
                end else if (!req_we) begin
                    w_state_nxt = LD;
                end else if (w_subword) begin
                    w_state_nxt = RD;
                end else begin
                    w_state_nxt = ST;
                end
            end
            LD:      w_state_nxt = RESP;
            ST:      w_state_nxt = RESP;
            RD:      w_state_nxt = WR;
            WR:      w_state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request capture, old-word capture for RMW, and response data/error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx   <= '0;
            r_lo    <= 2'b00;
            r_size  <= 2'b00;
            r_uns   <= 1'b0;
            r_wdata <= '0;
            r_old   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_idx   <= req_addr[M+1:2];
            r_lo    <= req_addr[1:0];
            r_size  <= req_size;
            r_uns   <= req_unsigned;
            r_wdata <= req_wdata;
            r_rdata <= '0;
            r_err   <= w_misalign;
        end else if (r_state == LD) begin
            r_rdata <= w_load;
        end else if (r_state == RD) begin
            r_old   <= mem_data_r;
        end
    end

    mem_lsu_lane #(.N(N)) u_lane (
        .i_rdata    (mem_data_r),
        .i_old      (r_old),
        .i_wdata    (r_wdata),
        .i_addr_lo  (r_lo),
        .i_size     (r_size),
        .i_unsigned (r_uns),
        .o_load     (w_load),
        .o_merge    (w_merge)
    );

    assign req_ready  = (r_state == IDLE);
    assign rsp_valid  = (r_state == RESP);
    assign rsp_rdata  = r_rdata;
    assign rsp_err    = r_err;
    assign mem_adrs_r = r_idx;
    assign mem_adrs_w = r_idx;
    assign mem_WE     = (r_state == ST) || (r_state == WR);
    assign mem_data_w = (r_state == WR) ? w_merge : r_wdata;

endmodule
